// File: rtl/pc_redirect.sv
// Fetch-address sequencer: issues word-aligned instruction fetches, steers to
// branch/jump targets, squashes in-flight requests on the wrong path, honours stalls.
module pc_redirect #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_valid,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        stall,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        fetch_valid,
   output logic [31:0] pc_f,
   output logic        flush_d,
   output logic        flush_e,
   output logic        misalign_err
);

   typedef enum logic [1:0] {FETCH, KILL, HOLD} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic        kill_q, kill_d;
   logic        misalign_q, misalign_d;
   logic [31:0] tgt_q, tgt_d;

   logic        branch_redir;
   logic        redirect;
   logic        bad_tgt;
   logic        good_redir;
   logic [31:0] target;

   // The branch is older than a concurrent jump, so its target takes priority.
   always_comb begin
      branch_redir = branch_valid & branch_taken;
      redirect     = branch_redir | jump_valid;
      target       = branch_redir ? branch_target : jump_target;
      bad_tgt      = redirect & (target[1:0] != 2'b00);
      good_redir   = redirect & ~bad_tgt;
   end

   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      addr_d        = addr_q;
      fetch_valid_d = 1'b0;
      pc_f_d        = pc_f_q;
      kill_d        = good_redir;
      misalign_d    = bad_tgt;
      tgt_d         = tgt_q;
      case (state_q)
         FETCH: begin
            if (req_q && !imem_ack) begin
               // Request cannot be withdrawn: remember where to go once it returns.
               if (good_redir) begin
                  state_d = KILL;
                  tgt_d   = target;
               end
            end else begin
               if (good_redir) begin
                  addr_d = target;
               end else if (req_q) begin
                  fetch_valid_d = 1'b1;
                  pc_f_d        = addr_q;
                  addr_d        = addr_q + 32'd4;
               end
               req_d   = ~stall;
               state_d = stall ? HOLD : FETCH;
            end
         end
         KILL: begin
            if (good_redir) begin
               tgt_d = target;
            end
            if (imem_ack) begin
               addr_d  = good_redir ? target : tgt_q;
               req_d   = ~stall;
               state_d = stall ? HOLD : FETCH;
            end
         end
         HOLD: begin
            if (good_redir) begin
               addr_d = target;
            end
            if (!stall) begin
               req_d   = 1'b1;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= FETCH;
         req_q         <= 1'b0;
         addr_q        <= RESET_PC;
         fetch_valid_q <= 1'b0;
         pc_f_q        <= 32'h0000_0000;
         kill_q        <= 1'b0;
         misalign_q    <= 1'b0;
         tgt_q         <= 32'h0000_0000;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         addr_q        <= addr_d;
         fetch_valid_q <= fetch_valid_d;
         pc_f_q        <= pc_f_d;
         kill_q        <= kill_d;
         misalign_q    <= misalign_d;
         tgt_q         <= tgt_d;
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = addr_q;
   assign fetch_valid  = fetch_valid_q;
   assign pc_f         = pc_f_q;
   assign flush_d      = kill_q;
   assign flush_e      = kill_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_redirect.sv
// Bench for pc_redirect: directed scenarios then random traffic, all compared
// against a request/pending-redirect reference model.
module tb_pc_redirect;

   logic        clk = 1'b0;
   logic        reset;
   logic        branch_valid, branch_taken, jump_valid, stall, imem_ack;
   logic [31:0] branch_target, jump_target;
   logic        imem_req, fetch_valid, flush_d, flush_e, misalign_err;
   logic [31:0] imem_addr, pc_f;

   int total = 0;
   int fails = 0;

   // Reference model state: is a request on the bus, its address, and a
   // redirect still waiting to be applied.
   bit          m_req;
   logic [31:0] m_addr;
   bit          m_pend;
   logic [31:0] m_ptgt;
   bit          m_fv, m_flush, m_mis;
   logic [31:0] m_pcf;

   pc_redirect #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .branch_valid(branch_valid), .branch_taken(branch_taken), .branch_target(branch_target),
      .jump_valid(jump_valid), .jump_target(jump_target),
      .stall(stall), .imem_ack(imem_ack),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .fetch_valid(fetch_valid), .pc_f(pc_f),
      .flush_d(flush_d), .flush_e(flush_e), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_req = 0; m_addr = 32'h0; m_pend = 0; m_ptgt = 32'h0;
      m_fv = 0; m_flush = 0; m_mis = 0; m_pcf = 32'h0;
   endtask

   task automatic model_edge();
      bit          redir, bad, good;
      logic [31:0] tgt;
      redir = (branch_valid && branch_taken) || jump_valid;
      tgt   = (branch_valid && branch_taken) ? branch_target : jump_target;
      bad   = redir && (tgt[1:0] != 2'b00);
      good  = redir && !bad;
      m_flush = good;
      m_mis   = bad;
      m_fv    = 0;
      if (good) begin
         m_pend = 1;
         m_ptgt = tgt;
      end
      if (!(m_req && !imem_ack)) begin
         if (m_req && !m_pend) begin
            m_fv   = 1;
            m_pcf  = m_addr;
            m_addr = m_addr + 32'd4;
         end
         if (m_pend) begin
            m_addr = m_ptgt;
            m_pend = 0;
         end
         m_req = !stall;
      end
   endtask

   task automatic check_all();
      chk("imem_req", imem_req, m_req);
      chk("imem_addr", imem_addr, m_addr);
      chk("fetch_valid", fetch_valid, m_fv);
      chk("pc_f", pc_f, m_pcf);
      chk("flush_d", flush_d, m_flush);
      chk("flush_e", flush_e, m_flush);
      chk("misalign_err", misalign_err, m_mis);
   endtask

   task automatic step(input bit bv, input bit bt, input logic [31:0] btg,
                       input bit jv, input logic [31:0] jtg, input bit st, input bit ak);
      branch_valid = bv; branch_taken = bt; branch_target = btg;
      jump_valid = jv; jump_target = jtg; stall = st; imem_ack = ak;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b0;
      branch_valid = 0; branch_taken = 0; branch_target = 0;
      jump_valid = 0; jump_target = 0; stall = 0; imem_ack = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b1;

      // First edge after reset issues RESET_PC, then sequential fetch with ack every cycle
      step(0, 0, 0, 0, 0, 0, 0);
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 32'h0);
      repeat (4) step(0, 0, 0, 0, 0, 0, 1);
      chk("seq_addr", imem_addr, 32'h10);
      chk("seq_pcf", pc_f, 32'hC);

      // Taken branch coincident with ack
      step(1, 1, 32'h100, 0, 0, 0, 1);
      chk("br_ack_fv", fetch_valid, 0);
      chk("br_ack_addr", imem_addr, 32'h100);
      chk("br_ack_flush", flush_d, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("flush_one_cycle", flush_e, 0);

      // Jump while 0x20 outstanding, ack three cycles later
      step(0, 0, 0, 1, 32'h20, 0, 1);
      step(0, 0, 0, 1, 32'h200, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("kill_hold_addr", imem_addr, 32'h20);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("kill_ack_fv", fetch_valid, 0);
      chk("kill_ack_addr", imem_addr, 32'h200);

      // Branch beats jump in the same cycle
      step(1, 1, 32'h300, 1, 32'h400, 0, 1);
      chk("branch_priority", imem_addr, 32'h300);

      // Misaligned target is ignored
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 32'h102, 0, 0, 0, 1);
      chk("misalign_pulse", misalign_err, 1);
      chk("misalign_noflush", flush_d, 0);
      chk("misalign_seq", imem_addr, 32'h308);

      // Stall after ack at 0x8
      step(0, 0, 0, 1, 32'h8, 0, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_addr", imem_addr, 32'hC);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("resume_req", imem_req, 1);
      chk("resume_addr", imem_addr, 32'hC);

      // Address wrap
      step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pcf", pc_f, 32'hFFFF_FFFC);

      // Not-taken branch does nothing
      step(1, 0, 32'h500, 0, 0, 0, 0);
      chk("nt_flush", flush_d, 0);

      // Redirect during stall overrides held address
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 32'h600, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("stall_redir_addr", imem_addr, 32'h600);

      // Newer redirect replaces the latched one while killing
      step(0, 0, 0, 1, 32'h700, 0, 0);
      step(1, 1, 32'h800, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("kill_overwrite", imem_addr, 32'h800);

      // Asynchronous reset with a squashed request pending
      step(0, 0, 0, 1, 32'h900, 0, 0);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("post_reset_pcf", pc_f, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] bt_r, jt_r;
         bt_r = $urandom & 32'h0000_FFFC;
         jt_r = $urandom & 32'h0000_FFFC;
         if ($urandom_range(0, 5) == 0) bt_r[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 5) == 0) jt_r[1:0] = 2'($urandom_range(1, 3));
         step($urandom_range(0, 7) == 0, 1'($urandom), bt_r,
              $urandom_range(0, 9) == 0, jt_r,
              $urandom_range(0, 3) == 0, 1'($urandom));
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
